// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencing.
// Outputs decode combinationally from state; FETCH/MEM_RD/MEM_WR stall on mem_rdy.
module mc_ctrl_fsm #(
    parameter int RST_PC_HOLD = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_rdy,
    output logic       pc_wr,
    output logic [1:0] pc_sel,
    output logic       ir_wr,
    output logic       reg_wr,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_sel,
    output logic       alu_srcb,
    output logic       ext_op,
    output logic [2:0] alu_op,
    output logic       dm_rd,
    output logic       dm_wr,
    output logic       ill_op
);
    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_JR   = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;
    localparam logic [2:0] ALU_AND = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    localparam logic [2:0] HOLD_LAST = 3'(RST_PC_HOLD - 1);

    typedef enum logic [3:0] {
        S_INIT, FETCH, DECODE, EXE_R, EXE_I, MEM_ADR, MEM_RD,
        MEM_WB, MEM_WR, WB_R, WB_I, BRANCH, JUMP
    } state_t;

    state_t     state, next_state;
    logic [2:0] hold_cnt;

    // R-type funct decode shared by DECODE (legality) and EXE_R (ALU select)
    logic       r_alu_ok;
    logic [2:0] r_alu_op;
    always_comb begin
        r_alu_ok = 1'b1;
        r_alu_op = ALU_ADD;
        unique case (funct)
            FN_ADDU: r_alu_op = ALU_ADD;
            FN_SUBU: r_alu_op = ALU_SUB;
            FN_AND:  r_alu_op = ALU_AND;
            FN_OR:   r_alu_op = ALU_OR;
            FN_SLT:  r_alu_op = ALU_SLT;
            default: r_alu_ok = 1'b0;
        endcase
    end

    logic is_jr;
    logic i_is_addiu;
    assign is_jr      = (opcode == OP_R) && (funct == FN_JR);
    assign i_is_addiu = (opcode == OP_ADDIU);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_INIT;
            hold_cnt <= 3'd0;
        end else begin
            state <= next_state;
            if (state == S_INIT && hold_cnt != HOLD_LAST)
                hold_cnt <= hold_cnt + 3'd1;
            else
                hold_cnt <= 3'd0;
        end
    end

    always_comb begin
        next_state = state;
        pc_wr      = 1'b0;
        pc_sel     = 2'd0;
        ir_wr      = 1'b0;
        reg_wr     = 1'b0;
        reg_dst    = 2'd0;
        wd_sel     = 2'd0;
        alu_srcb   = 1'b0;
        ext_op     = 1'b0;
        alu_op     = ALU_ADD;
        dm_rd      = 1'b0;
        dm_wr      = 1'b0;
        ill_op     = 1'b0;
        // Gating on rst keeps memory/write enables low the instant reset rises
        if (!rst) begin
            unique case (state)
                S_INIT: if (hold_cnt == HOLD_LAST) next_state = FETCH;
                FETCH: if (mem_rdy) begin
                    ir_wr      = 1'b1;
                    pc_wr      = 1'b1;
                    next_state = DECODE;
                end
                DECODE: begin
                    unique case (opcode)
                        OP_R: begin
                            if (is_jr)         next_state = JUMP;
                            else if (r_alu_ok) next_state = EXE_R;
                            else begin
                                next_state = FETCH;
                                ill_op     = 1'b1;
                            end
                        end
                        OP_LW, OP_SW:      next_state = MEM_ADR;
                        OP_ORI, OP_ADDIU:  next_state = EXE_I;
                        OP_BEQ:            next_state = BRANCH;
                        OP_J, OP_JAL:      next_state = JUMP;
                        default: begin
                            next_state = FETCH;
                            ill_op     = 1'b1;
                        end
                    endcase
                end
                EXE_R: begin
                    alu_op     = r_alu_op;
                    next_state = WB_R;
                end
                WB_R: begin
                    reg_wr     = 1'b1;
                    reg_dst    = 2'd1;
                    next_state = FETCH;
                end
                EXE_I, WB_I: begin
                    alu_srcb = 1'b1;
                    ext_op   = i_is_addiu;
                    alu_op   = i_is_addiu ? ALU_ADD : ALU_OR;
                    if (state == WB_I) begin
                        reg_wr     = 1'b1;
                        next_state = FETCH;
                    end else begin
                        next_state = WB_I;
                    end
                end
                MEM_ADR: begin
                    alu_srcb   = 1'b1;
                    ext_op     = 1'b1;
                    next_state = (opcode == OP_SW) ? MEM_WR : MEM_RD;
                end
                MEM_RD: begin
                    dm_rd = 1'b1;
                    if (mem_rdy) next_state = MEM_WB;
                end
                MEM_WB: begin
                    reg_wr     = 1'b1;
                    wd_sel     = 2'd1;
                    next_state = FETCH;
                end
                MEM_WR: begin
                    dm_wr = 1'b1;
                    if (mem_rdy) next_state = FETCH;
                end
                BRANCH: begin
                    alu_op     = ALU_SUB;
                    pc_sel     = 2'd1;
                    pc_wr      = zero;
                    next_state = FETCH;
                end
                JUMP: begin
                    pc_wr      = 1'b1;
                    next_state = FETCH;
                    if (is_jr) begin
                        pc_sel = 2'd3;
                    end else begin
                        pc_sel = 2'd2;
                        if (opcode == OP_JAL) begin
                            reg_wr  = 1'b1;
                            reg_dst = 2'd2;
                            wd_sel  = 2'd2;
                        end
                    end
                end
                default: next_state = FETCH;
            endcase
        end
    end
endmodule
